// File: rtl/hazard_ctrl_unit_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | hazard_ctrl_unit_if: operand, forwarding and stall/flush bundle  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface hazard_ctrl_unit_if #(
  parameter int REGW = 5,
  parameter int NFWD = 2
);
  localparam int SELW = $clog2(NFWD + 1);

  logic [REGW-1:0]      ifid_rs;
  logic [REGW-1:0]      ifid_rt;
  logic                 ifid_uses_rs;
  logic                 ifid_uses_rt;
  logic [REGW-1:0]      idex_rs;
  logic [REGW-1:0]      idex_rt;
  logic [REGW-1:0]      idex_rd;
  logic                 idex_memread;
  logic                 idex_memwrite;
  logic                 idex_mc_start;
  logic [NFWD-1:0]      fwd_wen;
  logic [NFWD*REGW-1:0] fwd_dst;
  logic                 branch_taken;

  logic [SELW-1:0]      forwarda_sel;
  logic [SELW-1:0]      forwardb_sel;
  logic [SELW-1:0]      store_fwd_sel;
  logic                 stall_id;
  logic                 stall_ex;
  logic                 flush_ifid;
  logic                 flush_idex;
  logic                 mc_busy;
  logic                 mc_done;

  modport master (
    output ifid_rs, ifid_rt, ifid_uses_rs, ifid_uses_rt,
    output idex_rs, idex_rt, idex_rd, idex_memread, idex_memwrite, idex_mc_start,
    output fwd_wen, fwd_dst, branch_taken,
    input  forwarda_sel, forwardb_sel, store_fwd_sel,
    input  stall_id, stall_ex, flush_ifid, flush_idex, mc_busy, mc_done
  );

  modport slave (
    input  ifid_rs, ifid_rt, ifid_uses_rs, ifid_uses_rt,
    input  idex_rs, idex_rt, idex_rd, idex_memread, idex_memwrite, idex_mc_start,
    input  fwd_wen, fwd_dst, branch_taken,
    output forwarda_sel, forwardb_sel, store_fwd_sel,
    output stall_id, stall_ex, flush_ifid, flush_idex, mc_busy, mc_done
  );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | hazard_ctrl_unit: forwarding select, load-use, MUL/DIV freeze    |
// | and branch flush control for the pipelined core. Rev 1.0         |
// +------------------------------------------------------------------+
module hazard_ctrl_unit #(
  parameter int REGW     = 5,
  parameter int NFWD     = 2,
  parameter int LOAD_LAT = 1,
  parameter int MC_LAT   = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  hazard_ctrl_unit_if.slave  hz
);
  localparam int SELW = $clog2(NFWD + 1);
  localparam int LCW  = LOAD_LAT;
  localparam int MCW  = $clog2(MC_LAT);

  typedef enum logic [0:0] {
    MC_IDLE = 1'b0,
    MC_BUSY = 1'b1
  } mc_state_e;

  mc_state_e       state_q, state_d;
  logic [LCW-1:0]  lu_cnt_q, lu_cnt_d;
  logic [MCW-1:0]  mc_cnt_q, mc_cnt_d;

  logic [SELW-1:0] w_sel_a;
  logic [SELW-1:0] w_sel_rt;
  logic            w_lu_hit;
  logic            w_stall_ex;
  logic            w_mc_done;
  logic            w_stall_id;
  logic            w_flush;

  // Descending scan so the youngest matching stage overwrites older ones.
  function automatic logic [SELW-1:0] match_f(
    input logic [REGW-1:0]      r,
    input logic [NFWD-1:0]      wen,
    input logic [NFWD*REGW-1:0] dst
  );
    logic [SELW-1:0] sel;
    sel = '0;
    for (int k = NFWD - 1; k >= 0; k--) begin
      if (wen[k] && (dst[k*REGW +: REGW] == r) && (r != '0)) begin
        sel = SELW'(k + 1);
      end
    end
    return sel;
  endfunction

  assign w_sel_a  = match_f(hz.idex_rs, hz.fwd_wen, hz.fwd_dst);
  assign w_sel_rt = match_f(hz.idex_rt, hz.fwd_wen, hz.fwd_dst);

  assign w_lu_hit = hz.idex_memread && (hz.idex_rd != '0) &&
                    ((hz.ifid_uses_rs && (hz.idex_rd == hz.ifid_rs)) ||
                     (hz.ifid_uses_rt && (hz.idex_rd == hz.ifid_rt)));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= MC_IDLE;
      mc_cnt_q <= '0;
      lu_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      mc_cnt_q <= mc_cnt_d;
      lu_cnt_q <= lu_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mc_cnt_d   = mc_cnt_q;
    w_stall_ex = 1'b0;
    w_mc_done  = 1'b0;
    unique case (state_q)
      MC_IDLE: begin
        if (hz.idex_mc_start) begin
          w_stall_ex = 1'b1;
          state_d    = MC_BUSY;
          mc_cnt_d   = MCW'(MC_LAT - 2);
        end
      end
      MC_BUSY: begin
        if (mc_cnt_q != '0) begin
          w_stall_ex = 1'b1;
          mc_cnt_d   = mc_cnt_q - MCW'(1);
        end else begin
          w_mc_done  = 1'b1;
          state_d    = MC_IDLE;
        end
      end
      default: state_d = MC_IDLE;
    endcase
  end

  // stall_ex freezes the load-use counter; a branch clears it.
  always_comb begin
    lu_cnt_d   = lu_cnt_q;
    w_stall_id = 1'b0;
    w_flush    = 1'b0;
    if (w_stall_ex) begin
      lu_cnt_d = lu_cnt_q;
    end else if (hz.branch_taken) begin
      w_flush  = 1'b1;
      lu_cnt_d = '0;
    end else begin
      w_stall_id = w_lu_hit || (lu_cnt_q != '0);
      if (w_lu_hit && (lu_cnt_q == '0)) begin
        lu_cnt_d = LCW'(LOAD_LAT - 1);
      end else if (lu_cnt_q != '0) begin
        lu_cnt_d = lu_cnt_q - LCW'(1);
      end
    end
  end

  assign hz.forwarda_sel  = rst_i ? '0 : w_sel_a;
  assign hz.forwardb_sel  = (rst_i || hz.idex_memwrite)  ? '0 : w_sel_rt;
  assign hz.store_fwd_sel = (rst_i || !hz.idex_memwrite) ? '0 : w_sel_rt;
  assign hz.stall_id      = !rst_i && w_stall_id;
  assign hz.stall_ex      = !rst_i && w_stall_ex;
  assign hz.flush_ifid    = !rst_i && w_flush;
  assign hz.flush_idex    = !rst_i && w_flush;
  assign hz.mc_busy       = !rst_i && (state_q == MC_BUSY);
  assign hz.mc_done       = !rst_i && w_mc_done;
endmodule
`default_nettype wire
